// File: rtl/status_frame_receiver_pkg.sv
// Shared constants for the alarm status serial link.
// The controller-side transmitter packs its status word with these same
// definitions, so both ends agree on frame length and bit positions.
package status_frame_receiver_pkg;

    localparam int FRAME_LEN = 4;

    localparam int BIT_ARMED = 3;
    localparam int BIT_ALARM = 2;
    localparam int BIT_S1    = 1;
    localparam int BIT_S2    = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // An alarm can only be raised while the system is armed.
    function automatic logic frame_is_legal(input logic [FRAME_LEN-1:0] f);
        return !(f[BIT_ALARM] && !f[BIT_ARMED]);
    endfunction

endpackage

// File: rtl/status_blinker.sv
// Square-wave generator for the alarm LED. The phase restarts high whenever
// the enable rises, so the LED always begins a blink sequence lit.
module status_blinker #(
    parameter int BLINK_HALF = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic blink
);

    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;

    // Half-period counter; idles at zero with the phase preloaded high while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign blink = en & phase;

endmodule

// File: rtl/status_frame_receiver.sv
// Keypad-side receiver for the alarm controller's serial status link.
// Deserializes 4-bit frames, rejects malformed or illegal ones, waits for a
// run of identical frames before updating the displayed state, and drops the
// panel LEDs when the link watchdog expires.
module status_frame_receiver
    import status_frame_receiver_pkg::*;
#(
    parameter int CONFIRM_FRAMES = 2,
    parameter int LINK_TIMEOUT   = 64,
    parameter int BLINK_HALF     = 5000
) (
    input  logic                 SERCLK_OUT,
    input  logic                 RESET_IN,
    input  logic                 STATUS_SEND,
    input  logic                 STATUS_OUT,
    output logic [FRAME_LEN-1:0] STATUS_WORD,
    output logic                 LED_ARMED,
    output logic                 LED_ALARM,
    output logic                 LED_S1,
    output logic                 LED_S2,
    output logic                 LINK_OK,
    output logic                 FRAME_ERR
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    localparam int WD_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(LINK_TIMEOUT);
    localparam logic [WD_W-1:0] WD_TRIP  = WD_W'(LINK_TIMEOUT - 1);

    localparam logic [2:0] CONFIRM = 3'(CONFIRM_FRAMES);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [FRAME_LEN-2:0] shift_reg;

    logic                 last_bit;
    logic                 frame_done;
    logic                 framing_err;

    logic [FRAME_LEN-1:0] frame;
    logic                 frame_legal;
    logic [FRAME_LEN-1:0] candidate;
    logic [2:0]           match_cnt;
    logic [2:0]           match_next;
    logic                 confirm_now;

    logic [WD_W-1:0]      wd_cnt;
    logic                 timeout_now;

    logic                 blink;

    // FSM state register.
    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a strobe always (re)starts shifting, otherwise leave after the last bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (STATUS_SEND) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit && !STATUS_SEND) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM decodes: frame completion and a strobe arriving before the frame is complete.
    always_comb begin
        last_bit    = (bit_cnt == LAST_BIT);
        frame_done  = 1'b0;
        framing_err = 1'b0;
        if (state == SHIFT) begin
            frame_done  = last_bit;
            framing_err = STATUS_SEND && !last_bit;
        end
    end

    // Shift register and bit counter; the data line is ignored on the strobe edge itself.
    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (STATUS_SEND) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state == SHIFT) begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= {shift_reg[FRAME_LEN-3:0], STATUS_OUT};
        end
    end

    // Frame assembly, confirmation run length and watchdog trip decode.
    always_comb begin
        frame       = {shift_reg, STATUS_OUT};
        frame_legal = frame_is_legal(frame);
        if (frame == candidate) begin
            match_next = (match_cnt >= CONFIRM) ? CONFIRM : match_cnt + 3'd1;
        end else begin
            match_next = 3'd1;
        end
        confirm_now = frame_done && frame_legal && (match_next == CONFIRM);
        timeout_now = !frame_done && (wd_cnt == WD_TRIP);
    end

    // Confirmation, error reporting and link watchdog; a completed frame beats a timeout.
    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) begin
            candidate   <= '0;
            match_cnt   <= '0;
            wd_cnt      <= '0;
            STATUS_WORD <= '0;
            LINK_OK     <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            FRAME_ERR <= framing_err || (frame_done && !frame_legal);
            if (frame_done) begin
                wd_cnt <= '0;
                if (frame_legal) begin
                    candidate <= frame;
                    match_cnt <= match_next;
                    if (confirm_now) begin
                        STATUS_WORD <= frame;
                        LINK_OK     <= 1'b1;
                    end
                end else begin
                    match_cnt <= '0;
                end
            end else begin
                if (wd_cnt != WD_LIMIT) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                if (timeout_now) begin
                    LINK_OK   <= 1'b0;
                    match_cnt <= '0;
                end
            end
        end
    end

    status_blinker #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blinker (
        .clk   (SERCLK_OUT),
        .rst   (RESET_IN),
        .en    (STATUS_WORD[BIT_ALARM]),
        .blink (blink)
    );

    // Registered panel LEDs, all gated by link health.
    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) begin
            LED_ARMED <= 1'b0;
            LED_ALARM <= 1'b0;
            LED_S1    <= 1'b0;
            LED_S2    <= 1'b0;
        end else begin
            LED_ARMED <= STATUS_WORD[BIT_ARMED] & LINK_OK;
            LED_ALARM <= STATUS_WORD[BIT_ALARM] & LINK_OK & blink;
            LED_S1    <= STATUS_WORD[BIT_S1] & LINK_OK;
            LED_S2    <= STATUS_WORD[BIT_S2] & LINK_OK;
        end
    end

endmodule
